// File: rtl/axi_sram_slave_pkg.sv
// Shared encodings for the AXI SRAM responder: burst types, response codes,
// channel FSM states and the latched address-phase request.
package axi_sram_slave_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} rstate_e;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_req_t;

  // Decode error dominates a protocol error.
  function automatic logic [1:0] resp_sel(input logic dec, input logic slv);
    if (dec) return AXI_RESP_DECERR;
    if (slv) return AXI_RESP_SLVERR;
    return AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// An illegal WRAP length falls back to INCR stepping and flags wrap_err.
module axi_burst_addr
  import axi_sram_slave_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        wrap_err
);

  logic [31:0] step, incr_addr, win_mask;
  logic        len_ok;

  // Pick next address; WRAP keeps the upper bits of the aligned window.
  always_comb begin
    step      = 32'd1 << size;
    incr_addr = addr + step;
    len_ok    = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    win_mask  = (({24'd0, len} + 32'd1) << size) - 32'd1;
    next_addr = incr_addr;
    wrap_err  = 1'b0;
    case (burst)
      AXI_BURST_FIXED: next_addr = addr;
      AXI_BURST_WRAP: begin
        if (len_ok) next_addr = (addr & ~win_mask) | (incr_addr & win_mask);
        else        wrap_err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI responder in front of a word-addressed SRAM model. Independent read and
// write FSMs, one transaction in flight per channel, all outputs registered.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int          MEM_AW             = 16,
  parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
  parameter int          READ_LATENCY       = 1,
  parameter int          WRITE_RESP_LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [3:0]  awcache,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [3:0]  arcache,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  logic [31:0] mem [0:(2**MEM_AW)-1];

  // Cache attributes carry no meaning for a plain SRAM.
  logic unused_cache;
  assign unused_cache = ^{awcache, arcache};

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a - BASE_ADDR} < (33'd1 << (MEM_AW + 2)));
  endfunction

  function automatic logic [MEM_AW-1:0] widx(input logic [31:0] a);
    return MEM_AW'((a - BASE_ADDR) >> 2);
  endfunction

  // ---------------- write channel ----------------
  wstate_e     wst_q, wst_d;
  axi_req_t    w_q, w_d;
  logic [7:0]  wcnt_q, wcnt_d, wwait_q, wwait_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [3:0]  bid_q, bid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        wslv_q, wslv_d, wdec_q, wdec_d;
  logic [31:0] w_next;
  logic        w_wrap_err, mem_we, w_in;

  axi_burst_addr u_waddr (
    .addr(w_q.addr), .size(w_q.size), .len(w_q.len), .burst(w_q.burst),
    .next_addr(w_next), .wrap_err(w_wrap_err)
  );

  // Write FSM next state; a beat outside the decoded window is dropped.
  always_comb begin
    wst_d = wst_q; w_d = w_q; wcnt_d = wcnt_q; wwait_d = wwait_q;
    awready_d = awready_q; wready_d = wready_q; bvalid_d = bvalid_q;
    bid_d = bid_q; bresp_d = bresp_q; wslv_d = wslv_q; wdec_d = wdec_q;
    w_in = in_range(w_q.addr);
    mem_we = 1'b0;
    case (wst_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_d       = '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
          wcnt_d    = 8'd0;
          wslv_d    = 1'b0;
          wdec_d    = 1'b0;
          wst_d     = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          mem_we = w_in;
          if (!w_in) wdec_d = 1'b1;
          if ((wlast != (wcnt_q == w_q.len)) || w_wrap_err) wslv_d = 1'b1;
          w_d.addr = w_next;
          wcnt_d   = wcnt_q + 8'd1;
          if (wcnt_q == w_q.len) begin
            wready_d = 1'b0;
            if (WRITE_RESP_LATENCY > 0) begin
              wwait_d = 8'(WRITE_RESP_LATENCY - 1);
              wst_d   = W_WAIT;
            end else begin
              bvalid_d = 1'b1;
              bid_d    = w_q.id;
              bresp_d  = resp_sel(wdec_d, wslv_d);
              wst_d    = W_RESP;
            end
          end
        end
      end
      W_WAIT: begin
        if (wwait_q == 8'd0) begin
          bvalid_d = 1'b1;
          bid_d    = w_q.id;
          bresp_d  = resp_sel(wdec_q, wslv_q);
          wst_d    = W_RESP;
        end else begin
          wwait_d = wwait_q - 8'd1;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wst_d     = W_IDLE;
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end

  // SRAM byte writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[widx(w_q.addr)][8*b +: 8] <= wdata[8*b +: 8];
  end

  // ---------------- read channel ----------------
  rstate_e     rst_q, rst_d;
  axi_req_t    r_q, r_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [3:0]  rlat_q, rlat_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] r_next;
  logic        r_wrap_err, r_in_cur, r_in_nxt;

  axi_burst_addr u_raddr (
    .addr(r_q.addr), .size(r_q.size), .len(r_q.len), .burst(r_q.burst),
    .next_addr(r_next), .wrap_err(r_wrap_err)
  );

  // Read FSM next state; the next word is fetched on the accepting beat.
  always_comb begin
    rst_d = rst_q; r_d = r_q; rcnt_d = rcnt_q; rlat_d = rlat_q;
    arready_d = arready_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
    rid_d = rid_q; rdata_d = rdata_q; rresp_d = rresp_q;
    r_in_cur = in_range(r_q.addr);
    r_in_nxt = in_range(r_next);
    case (rst_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          arready_d = 1'b0;
          r_d       = '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
          rcnt_d    = 8'd0;
          rlat_d    = 4'(READ_LATENCY - 1);
          rst_d     = R_LAT;
        end
      end
      R_LAT: begin
        if (rlat_q == 4'd0) begin
          rvalid_d = 1'b1;
          rid_d    = r_q.id;
          rdata_d  = r_in_cur ? mem[widx(r_q.addr)] : 32'd0;
          rresp_d  = resp_sel(!r_in_cur, r_wrap_err);
          rlast_d  = (r_q.len == 8'd0);
          rst_d    = R_DATA;
        end else begin
          rlat_d = rlat_q - 4'd1;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rcnt_q == r_q.len) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            rst_d     = R_IDLE;
          end else begin
            r_d.addr = r_next;
            rcnt_d   = rcnt_q + 8'd1;
            rdata_d  = r_in_nxt ? mem[widx(r_next)] : 32'd0;
            rresp_d  = resp_sel(!r_in_nxt, r_wrap_err);
            rlast_d  = ((rcnt_q + 8'd1) == r_q.len);
          end
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  // Channel state and registered outputs; reset aborts any burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wst_q <= W_IDLE; w_q <= '0; wcnt_q <= '0; wwait_q <= '0;
      awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0;
      bid_q <= '0; bresp_q <= '0; wslv_q <= 1'b0; wdec_q <= 1'b0;
      rst_q <= R_IDLE; r_q <= '0; rcnt_q <= '0; rlat_q <= '0;
      arready_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0;
      rid_q <= '0; rdata_q <= '0; rresp_q <= '0;
    end else begin
      wst_q <= wst_d; w_q <= w_d; wcnt_q <= wcnt_d; wwait_q <= wwait_d;
      awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
      bid_q <= bid_d; bresp_q <= bresp_d; wslv_q <= wslv_d; wdec_q <= wdec_d;
      rst_q <= rst_d; r_q <= r_d; rcnt_q <= rcnt_d; rlat_q <= rlat_d;
      arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
      rid_q <= rid_d; rdata_q <= rdata_d; rresp_q <= rresp_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: stimulus pushes expected B/R responses
// into queues, a negedge monitor pops and compares on each handshake.
module tb_axi_sram_slave;

  logic        clk = 1'b0, reset = 1'b1;
  logic [3:0]  awid = '0, arid = '0, awcache = '0, arcache = '0;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic        awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        bready = 1'b1, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  axi_sram_slave #(.MEM_AW(10), .BASE_ADDR(32'h0), .READ_LATENCY(1), .WRITE_RESP_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awcache(awcache), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arcache(arcache), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];
  rexp_t re;
  bexp_t be;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] rs, input logic l);
    rexp_t e;
    e.id = id; e.data = d; e.resp = rs; e.last = l;
    rq.push_back(e);
  endtask

  task automatic push_b(input logic [3:0] id, input logic [1:0] rs);
    bexp_t e;
    e.id = id; e.resp = rs;
    bq.push_back(e);
  endtask

  // rready pattern: 0 always high, 1 toggling, 2 held low
  int rr_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       rready = 1'b1;
      1:       rready = ~rready;
      default: rready = 1'b0;
    endcase
  end

  // Monitor: latency, payload stability under stall, and scoreboard pops.
  int ar_hs_cyc = 0;
  bit lat_pend = 0, stall_v = 0;
  logic [31:0] st_data;
  logic [1:0]  st_resp;
  logic        st_last;
  logic [3:0]  st_id;
  always @(negedge clk) begin
    if (reset) begin
      stall_v = 0;
    end else begin
      if (lat_pend && rvalid) begin
        chk("rd_latency", cyc - ar_hs_cyc, 32'd1);
        lat_pend = 0;
      end
      if (stall_v && rvalid) begin
        chk("r_stable_data", rdata, st_data);
        chk("r_stable_ctl", {25'd0, st_id, st_resp, st_last}, {25'd0, rid, rresp, rlast});
      end
      stall_v = rvalid && !rready;
      st_data = rdata; st_resp = rresp; st_last = rlast; st_id = rid;
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
        else begin
          re = rq.pop_front();
          chk("rid", 32'(rid), 32'(re.id));
          chk("rdata", rdata, re.data);
          chk("rresp", 32'(rresp), 32'(re.resp));
          chk("rlast", 32'(rlast), 32'(re.last));
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
        else begin
          be = bq.pop_front();
          chk("bid", 32'(bid), 32'(be.id));
          chk("bresp", 32'(bresp), 32'(be.resp));
        end
      end
    end
  end

  task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
    bit ok = 0;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bt; awvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1; break; end
    end
    if (!ok) chk("aw_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
    bit ok = 0;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bt; arvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    if (!ok) chk("ar_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    ar_hs_cyc = cyc;
    lat_pend = 1;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
    bit ok = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wready) begin ok = 1; break; end
    end
    if (!ok) chk("w_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic write1(input logic [3:0] id, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] rs);
    push_b(id, rs);
    aw_send(id, a, 8'd0, 3'd2, 2'd1);
    w_send(d, s, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (rq.size() == 0 && bq.size() == 0 && !lat_pend) break;
      @(negedge clk);
    end
    if (rq.size() != 0 || bq.size() != 0 || lat_pend) begin
      chk("drain_timeout", 32'(rq.size() + bq.size()), 32'd0);
      rq.delete(); bq.delete(); lat_pend = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    chk("arready_at_release", 32'(arready), 32'd0);
    @(posedge clk); #1;
    chk("arready_after_rst", 32'(arready), 32'd1);
    chk("awready_after_rst", 32'(awready), 32'd1);

    // single beat with partial strobes over a cleared word
    write1(4'd1, 32'h100, 32'h0, 4'hF, 2'd0);
    write1(4'd2, 32'h100, 32'hDEADBEEF, 4'b0101, 2'd0);
    wait_idle();
    push_r(4'd3, 32'h00AD00EF, 2'd0, 1'b1);
    ar_send(4'd3, 32'h100, 8'd0, 3'd2, 2'd1);
    wait_idle();

    // INCR write 1..4, read back with rready toggling
    push_b(4'd4, 2'd0);
    aw_send(4'd4, 32'h200, 8'd3, 3'd2, 2'd1);
    for (int i = 0; i < 4; i++) w_send(32'(i + 1), 4'hF, i == 3);
    wait_idle();
    rr_mode = 1;
    for (int i = 0; i < 4; i++) push_r(4'd5, 32'(i + 1), 2'd0, i == 3);
    ar_send(4'd5, 32'h200, 8'd3, 3'd2, 2'd1);
    wait_idle();
    rr_mode = 0;

    // WRAP from 0x20C: 0x20C, 0x200, 0x204, 0x208
    push_r(4'd6, 32'd4, 2'd0, 1'b0);
    push_r(4'd6, 32'd1, 2'd0, 1'b0);
    push_r(4'd6, 32'd2, 2'd0, 1'b0);
    push_r(4'd6, 32'd3, 2'd0, 1'b1);
    ar_send(4'd6, 32'h20C, 8'd3, 3'd2, 2'd2);
    wait_idle();
    // illegal WRAP length steps as INCR and flags SLVERR
    push_r(4'd7, 32'd1, 2'd2, 1'b0);
    push_r(4'd7, 32'd2, 2'd2, 1'b0);
    push_r(4'd7, 32'd3, 2'd2, 1'b1);
    ar_send(4'd7, 32'h200, 8'd2, 3'd2, 2'd2);
    wait_idle();

    // decode: window is 0x000..0xFFF
    write1(4'd8, 32'h0, 32'hA5A5A5A5, 4'hF, 2'd0);
    write1(4'd9, 32'hFFC, 32'h0BADF00D, 4'hF, 2'd0);
    write1(4'd10, 32'h1000, 32'h12345678, 4'hF, 2'd3);
    wait_idle();
    push_r(4'd11, 32'hA5A5A5A5, 2'd0, 1'b1);
    ar_send(4'd11, 32'h0, 8'd0, 3'd2, 2'd1);
    wait_idle();
    push_r(4'd12, 32'h0, 2'd3, 1'b1);
    ar_send(4'd12, 32'h1000, 8'd0, 3'd2, 2'd1);
    wait_idle();
    push_r(4'd13, 32'h0BADF00D, 2'd0, 1'b0);
    push_r(4'd13, 32'h0, 2'd3, 1'b1);
    ar_send(4'd13, 32'hFFC, 8'd1, 3'd2, 2'd1);
    wait_idle();

    // AW and AR together on one word: read sees the old value
    write1(4'd14, 32'h300, 32'h11111111, 4'hF, 2'd0);
    wait_idle();
    push_b(4'd15, 2'd0);
    push_r(4'd1, 32'h11111111, 2'd0, 1'b1);
    fork
      aw_send(4'd15, 32'h300, 8'd0, 3'd2, 2'd1);
      w_send(32'h22222222, 4'hF, 1'b1);
      ar_send(4'd1, 32'h300, 8'd0, 3'd2, 2'd1);
    join
    wait_idle();
    push_r(4'd2, 32'h22222222, 2'd0, 1'b1);
    ar_send(4'd2, 32'h300, 8'd0, 3'd2, 2'd1);
    wait_idle();

    // early wlast: SLVERR, yet all three beats land
    push_b(4'd3, 2'd2);
    aw_send(4'd3, 32'h400, 8'd2, 3'd2, 2'd1);
    w_send(32'hA1, 4'hF, 1'b0);
    w_send(32'hA2, 4'hF, 1'b1);
    w_send(32'hA3, 4'hF, 1'b0);
    wait_idle();
    push_r(4'd4, 32'hA1, 2'd0, 1'b0);
    push_r(4'd4, 32'hA2, 2'd0, 1'b0);
    push_r(4'd4, 32'hA3, 2'd0, 1'b1);
    ar_send(4'd4, 32'h400, 8'd2, 3'd2, 2'd1);
    wait_idle();

    // reset in the middle of a stalled read burst
    rr_mode = 2;
    ar_send(4'd5, 32'h200, 8'd3, 3'd2, 2'd1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rvalid) break;
    end
    chk("burst_rvalid_seen", 32'(rvalid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_rvalid", 32'(rvalid), 32'd0);
    chk("midrst_arready", 32'(arready), 32'd0);
    chk("midrst_awready", 32'(awready), 32'd0);
    lat_pend = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("arready_at_release2", 32'(arready), 32'd0);
    @(posedge clk); #1;
    chk("arready_after_rst2", 32'(arready), 32'd1);
    rr_mode = 0;
    push_r(4'd6, 32'd1, 2'd0, 1'b1);
    ar_send(4'd6, 32'h200, 8'd0, 3'd2, 2'd1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI slave (responder) holding a word-addressed SRAM model. It serves the AXI master ports the CPU memory interface drives: single beats and INCR/FIXED/WRAP bursts. The block acts as the local memory behind the instruction and data AXI buses in the SoC top and testbenches. Read and write channels run independently and can be active at the same time.

Parameters:
MEM_AW, 16, word-address width; the memory has 2^MEM_AW 32-bit words.
BASE_ADDR, 32'h0000_0000, byte base address that the memory decodes.
READ_LATENCY, 1, cycles from AR handshake to first rvalid (range 1..15).
WRITE_RESP_LATENCY, 0, extra cycles between the last W beat and bvalid.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
awid/arid  in  4  transaction ID
awaddr/araddr  in  32  byte address
awlen/arlen  in  8  beats minus 1 (0..255)
awsize/arsize  in  3  bytes per beat = 2^size (0..2)
awburst/arburst  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP
awcache/arcache  in  4  accepted and ignored
awvalid/arvalid  in  1  address valid
awready/arready  out  1  address accepted
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  last write beat
wvalid  in  1  / wready out 1  write-data handshake
bid  out  4  / bresp out 2  / bvalid out 1  / bready in 1  write response
rid  out  4  / rdata out 32  / rresp out 2  / rlast out 1  / rvalid out 1  / rready in 1  read data

Behaviour:
- Reset is asynchronous and active-high. It forces every FSM to IDLE and drives every output to 0. awready and arready first assert in the cycle after reset deasserts.
- All outputs are registered. AXI rule: once a valid is asserted, the payload stays stable until ready.
- Write FSM states: W_IDLE, W_DATA, W_WAIT, W_RESP.
  - W_IDLE: awready=1. On awvalid it latches id, addr, len, size and burst, clears the beat counter and moves to W_DATA.
  - W_DATA: wready=1. On each wvalid beat it writes the bytes selected by wstrb at index addr[MEM_AW+1:2], advances the address and increments the counter.
  - After beat number len: go to W_WAIT if WRITE_RESP_LATENCY>0, otherwise to W_RESP.
  - If wlast disagrees with the counter (early or missing), set the SLVERR flag. The burst still ends after len+1 beats.
  - W_RESP: bvalid=1, bid=latched id. bresp = OKAY(0), SLVERR(2) or DECERR(3). Return to W_IDLE on bready.
- Read FSM states: R_IDLE, R_LAT, R_DATA.
  - R_IDLE: arready=1. On arvalid it latches the fields and loads the latency counter with READ_LATENCY-1.
  - R_LAT: counts down to 0, then loads rdata from the current address and enters R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rlast=(beat==len). On rready, advance the address and load the next word in the same cycle, with no bubble. After the last beat, return to R_IDLE.
- Address generation:
  - FIXED: address unchanged.
  - INCR: addr + 2^size.
  - WRAP: len must be 1, 3, 7 or 15. The address wraps inside a (len+1)*2^size byte aligned window. Any other len is treated as INCR and returns SLVERR.
- Address decode: the request is in range when addr-BASE_ADDR < 4*2^MEM_AW.
  - Out-of-range write beats are dropped and the response is DECERR.
  - Out-of-range read beats return rdata=0 and rresp=DECERR.
  - The check is made per beat.
- Read/write collision to the same word in the same cycle: rdata captures the old value; the write still completes.
- Sub-word sizes: rdata always returns the full 32-bit word. The write path honours wstrb only; size affects address increment only.
- No outstanding-transaction queue: at most one read and one write in flight at a time.
- Reset mid-burst aborts the burst. Memory contents are not cleared.

Decomposition:
- Add to defs.vh:
  - AXI_BURST_FIXED/INCR/WRAP
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR
  - W_*/R_* state encodings
- One sub-module, axi_burst_addr: a combinational next-address unit (addr, size, len, burst → next_addr, wrap_err). It is instantiated once per channel.

Test Plan:
- Single write at 0x100 (wdata 0xDEADBEEF, wstrb 4'b0101), then single read → bresp 0, rdata 0x00AD00EF from a zeroed memory, rresp 0, rlast=1, rvalid exactly READ_LATENCY cycles after the AR handshake.
- INCR write, len=3, size=2, at 0x200 with data 1..4; read back as INCR len=3 with rready toggling every other cycle → rdata 1,2,3,4 held stable while stalled, rlast only on beat 4.
- WRAP read, len=3, size=2, starting at 0x20C → beat addresses 0x20C, 0x200, 0x204, 0x208; arlen=2 with WRAP → rresp SLVERR.
- Address beyond BASE+4*2^MEM_AW → write bresp 3 with memory unchanged; read returns rdata 0 and rresp 3.
- Concurrent AW and AR in the same cycle to the same word → both accepted; read returns the old data, a later read returns the new data. Write burst with early wlast → bresp 2.
- Assert reset in the middle of an R_DATA burst → rvalid, arready and awready go to 0 immediately; arready rises one cycle after release; a new read succeeds.
